tx_link_ctrl: RTL and testbench

Transmit link-state controller for a single-lane JESD204B transmitter. It runs the local frame and multiframe (LMFC) counters and watches the receiver's SYNC~. It sequences the link through code-group synchronisation (CGS), initial lane alignment (ILA) and user data. It drives the stream-select and deassertion-frame-position inputs of the downstream TX link layer, and it tells the upstream transport layer when user data is accepted.

---
 rtl/tx_link_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_tx_link_ctrl.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_link_ctrl.sv
// -----------------------------------------------------------------------------
// tx_link_ctrl
// Transmit link-state controller for a single-lane JESD204B transmitter.
// Runs the local frame / multiframe (LMFC) counters, watches the receiver's
// SYNC~ and sequences the link through CGS -> WAIT_LMFC -> ILA -> DATA.
//
// Ports
//   clk                      character clock (single domain)
//   rst_n                    asynchronous active-low reset
//   i_sync_n                 receiver SYNC~, active low, synchronous to clk
//   o_link_mux[2:0]          stream select: 0 user data, 1 continuous K, 2 ILA
//   o_no_frame_de_assertion  frame index at which SYNC~ deassertion was seen
//   o_user_ready             high while in DATA
//   o_lmfc                   pulse on the last octet of each multiframe
//   o_frame_start            high on octet 0 of every frame
//   o_sync_err               pulse on a short SYNC~ assertion in ILA/DATA
// -----------------------------------------------------------------------------
module tx_link_ctrl #(
  parameter int unsigned F      = 8,
  parameter int unsigned K      = 4,
  parameter int unsigned ILA_MF = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sync_n,
  output logic [2:0] o_link_mux,
  output logic [4:0] o_no_frame_de_assertion,
  output logic       o_user_ready,
  output logic       o_lmfc,
  output logic       o_frame_start,
  output logic       o_sync_err
);

  localparam int unsigned OCT_W  = 4;
  localparam int unsigned FRM_W  = 5;
  localparam int unsigned ILA_W  = 3;
  localparam int unsigned LOW_W  = 12;
  localparam int unsigned MUX_W  = 3;
  localparam int unsigned THRESH = 5 * F + 9;

  localparam logic [OCT_W-1:0] OCT_LAST   = OCT_W'(F - 1);
  localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(K - 1);
  localparam logic [ILA_W-1:0] ILA_LAST   = ILA_W'(ILA_MF - 1);
  localparam logic [LOW_W-1:0] LOW_RESYNC = LOW_W'(THRESH - 1);
  localparam logic [LOW_W-1:0] LOW_THRESH = LOW_W'(THRESH);
  localparam logic [LOW_W-1:0] LOW_MAX    = '1;

  localparam logic [MUX_W-1:0] MUX_DATA = MUX_W'(0);
  localparam logic [MUX_W-1:0] MUX_K    = MUX_W'(1);
  localparam logic [MUX_W-1:0] MUX_ILA  = MUX_W'(2);

  // o_lmfc reset value decoded from zeroed counters
  localparam logic LMFC_RST = (F == 1) && (K == 1);

  typedef enum logic [1:0] {
    S_CGS       = 2'd0,
    S_WAIT_LMFC = 2'd1,
    S_ILA       = 2'd2,
    S_DATA      = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [OCT_W-1:0] octet_cnt;
  logic [FRM_W-1:0] frame_cnt;
  logic [OCT_W-1:0] octet_nxt_c;
  logic [FRM_W-1:0] frame_nxt_c;
  logic             boundary_c;

  logic             sync_q;
  logic [LOW_W-1:0] low_cnt;
  logic             resync_c;
  logic             short_err_c;

  logic [ILA_W-1:0] ila_cnt_q;
  logic [ILA_W-1:0] ila_cnt_d;

  logic [MUX_W-1:0] link_mux_d;
  logic [FRM_W-1:0] nfd_d;
  logic             user_ready_d;
  logic             sync_err_d;

  // Next values of the free-running octet / frame counters
  always_comb begin
    octet_nxt_c = octet_cnt + OCT_W'(1);
    frame_nxt_c = frame_cnt;
    if (octet_cnt == OCT_LAST) begin
      octet_nxt_c = '0;
      if (frame_cnt == FRM_LAST) begin
        frame_nxt_c = '0;
      end else begin
        frame_nxt_c = frame_cnt + FRM_W'(1);
      end
    end
  end

  assign boundary_c = (octet_cnt == OCT_LAST) && (frame_cnt == FRM_LAST);

  // Counters; o_lmfc / o_frame_start are decoded from the next count so they
  // line up with the counter values they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      octet_cnt     <= '0;
      frame_cnt     <= '0;
      o_frame_start <= 1'b1;
      o_lmfc        <= LMFC_RST;
    end else begin
      octet_cnt     <= octet_nxt_c;
      frame_cnt     <= frame_nxt_c;
      o_frame_start <= (octet_nxt_c == '0);
      o_lmfc        <= (octet_nxt_c == OCT_LAST) && (frame_nxt_c == FRM_LAST);
    end
  end

  // SYNC~ sampling and low-run length (count of preceding low cycles)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 1'b0;
      low_cnt <= '0;
    end else begin
      sync_q <= i_sync_n;
      if (sync_q) begin
        low_cnt <= '0;
      end else if (low_cnt != LOW_MAX) begin
        low_cnt <= low_cnt + LOW_W'(1);
      end
    end
  end

  // THRESH-th consecutive low cycle forces a resync
  assign resync_c    = !sync_q && (low_cnt >= LOW_RESYNC);
  // Rising SYNC~ after a low run shorter than THRESH is an error report
  assign short_err_c = sync_q && (low_cnt != '0) && (low_cnt < LOW_THRESH);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CGS;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    ila_cnt_d    = ila_cnt_q;
    nfd_d        = o_no_frame_de_assertion;
    sync_err_d   = 1'b0;
    link_mux_d   = MUX_K;
    user_ready_d = 1'b0;

    case (state_q)
      S_CGS: begin
        if (sync_q) begin
          nfd_d   = frame_cnt;
          state_d = S_WAIT_LMFC;
        end
      end
      S_WAIT_LMFC: begin
        if (!sync_q) begin
          state_d = S_CGS;
        end else if (boundary_c) begin
          state_d   = S_ILA;
          ila_cnt_d = '0;
        end
      end
      S_ILA: begin
        sync_err_d = short_err_c;
        if (boundary_c) begin
          ila_cnt_d = ila_cnt_q + ILA_W'(1);
        end
        // Resync wins over the ILA -> DATA step on the same cycle
        if (resync_c) begin
          state_d = S_CGS;
        end else if (boundary_c && (ila_cnt_q == ILA_LAST)) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        sync_err_d = short_err_c;
        if (resync_c) begin
          state_d = S_CGS;
        end
      end
      default: begin
        state_d = S_CGS;
      end
    endcase

    case (state_d)
      S_ILA:   link_mux_d = MUX_ILA;
      S_DATA:  link_mux_d = MUX_DATA;
      default: link_mux_d = MUX_K;
    endcase
    user_ready_d = (state_d == S_DATA);
  end

  // Registered FSM outputs and ILA multiframe counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ila_cnt_q               <= '0;
      o_link_mux              <= MUX_K;
      o_no_frame_de_assertion <= '0;
      o_user_ready            <= 1'b0;
      o_sync_err              <= 1'b0;
    end else begin
      ila_cnt_q               <= ila_cnt_d;
      o_link_mux              <= link_mux_d;
      o_no_frame_de_assertion <= nfd_d;
      o_user_ready            <= user_ready_d;
      o_sync_err              <= sync_err_d;
    end
  end

endmodule

// File: tb/tb_tx_link_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tx_link_ctrl
// Self-checking bench for tx_link_ctrl (F=8, K=4, ILA_MF=4). A behavioural
// model tracks absolute cycle time since reset release, the SYNC~ low-run
// length and the time ILA started, and predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_tx_link_ctrl;

  localparam int F       = 8;
  localparam int K       = 4;
  localparam int ILA_MF  = 4;
  localparam int MF      = F * K;
  localparam int THRESH  = 5 * F + 9;
  localparam int ILA_LEN = ILA_MF * MF;

  localparam int M_CGS  = 0;
  localparam int M_WAIT = 1;
  localparam int M_ILA  = 2;
  localparam int M_DATA = 3;

  // {mux, nfd, user_ready, lmfc, frame_start, sync_err}
  localparam logic [11:0] RST_VEC = {3'd1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_sync_n;
  logic [2:0] o_link_mux;
  logic [4:0] o_no_frame_de_assertion;
  logic       o_user_ready;
  logic       o_lmfc;
  logic       o_frame_start;
  logic       o_sync_err;
  logic [11:0] obs;

  int checks = 0;
  int fails  = 0;

  // model state
  int t;
  int mode;
  int ila_start;
  logic m_sq;
  int m_low;
  int m_low_prev;
  int e_mux;
  int e_nfd;
  logic e_ready;
  logic e_err;

  always #5 clk = ~clk;

  tx_link_ctrl #(.F(F), .K(K), .ILA_MF(ILA_MF)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .i_sync_n                (i_sync_n),
    .o_link_mux              (o_link_mux),
    .o_no_frame_de_assertion (o_no_frame_de_assertion),
    .o_user_ready            (o_user_ready),
    .o_lmfc                  (o_lmfc),
    .o_frame_start           (o_frame_start),
    .o_sync_err              (o_sync_err)
  );

  assign obs = {o_link_mux, o_no_frame_de_assertion, o_user_ready,
                o_lmfc, o_frame_start, o_sync_err};

  function automatic logic [11:0] exp_vec();
    logic lm;
    logic fs;
    lm = ((t % MF) == MF - 1);
    fs = ((t % F) == 0);
    return {3'(e_mux), 5'(e_nfd), e_ready, lm, fs, e_err};
  endfunction

  // cycle 0 = counters at zero, just after reset release
  task automatic model_init();
    t          = 0;
    mode       = M_CGS;
    ila_start  = 0;
    m_sq       = 1'b0;
    m_low      = 1;
    m_low_prev = 0;
    e_mux      = 1;
    e_nfd      = 0;
    e_ready    = 1'b0;
    e_err      = 1'b0;
  endtask

  // Drive i_sync_n for the current cycle, predict the next cycle, advance.
  task automatic step(input logic v);
    logic boundary;
    logic n_err;
    i_sync_n = v;
    boundary = ((t % MF) == MF - 1);
    n_err    = 1'b0;
    if (mode == M_CGS) begin
      if (m_sq) begin
        e_nfd = (t / F) % K;
        mode  = M_WAIT;
      end
    end else if (mode == M_WAIT) begin
      if (!m_sq) mode = M_CGS;
      else if (boundary) begin
        mode      = M_ILA;
        ila_start = t + 1;
      end
    end else begin
      if (m_sq && m_low_prev > 0 && m_low_prev < THRESH) n_err = 1'b1;
      if (!m_sq && m_low >= THRESH) mode = M_CGS;
      else if (mode == M_ILA && (t + 1 - ila_start) == ILA_LEN) mode = M_DATA;
    end
    e_err   = n_err;
    e_mux   = (mode == M_DATA) ? 0 : (mode == M_ILA) ? 2 : 1;
    e_ready = (mode == M_DATA);
    m_low_prev = m_low;
    t     = t + 1;
    m_sq  = v;
    m_low = v ? 0 : m_low + 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int n_lmfc;
    int n_fs;
    rst_n    = 1'b0;
    i_sync_n = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== RST_VEC) begin
      fails++;
      $display("FAIL reset_values got %h exp %h", obs, RST_VEC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_init();
    checks++;
    if (obs !== exp_vec()) begin
      fails++;
      $display("FAIL reset_cycle0 got %h exp %h", obs, exp_vec());
    end
    n_lmfc = 0;
    n_fs   = 0;
    repeat (64) begin
      step(1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL reset_idle t=%0d got %h exp %h", t, obs, exp_vec());
      end
      n_lmfc += int'(o_lmfc);
      n_fs   += int'(o_frame_start);
    end
    checks++;
    if (n_lmfc != 2 || n_fs != 8) begin
      fails++;
      $display("FAIL reset_pulse_counts lmfc=%0d fs=%0d exp 2 and 8", n_lmfc, n_fs);
    end
  endtask

  task automatic test_bringup();
    int rise_t;
    int ila_t;
    int data_t;
    ila_t  = -1;
    data_t = -1;
    while ((t % MF) != 18) begin
      step(1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL bringup_wait t=%0d got %h exp %h", t, obs, exp_vec());
      end
    end
    step(1'b1);
    rise_t = t;
    for (int i = 0; i < 400 && data_t < 0; i++) begin
      step(1'b1);
      checks++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL bringup_seq t=%0d got %h exp %h", t, obs, exp_vec());
      end
      if (ila_t < 0 && o_link_mux == 3'd2) ila_t = t;
      if (data_t < 0 && o_link_mux == 3'd0) data_t = t;
    end
    checks++;
    if (o_no_frame_de_assertion !== 5'd2) begin
      fails++;
      $display("FAIL bringup_nfd got %0d exp 2", o_no_frame_de_assertion);
    end
    checks++;
    if (ila_t - rise_t != 13 || (ila_t % MF) != 0) begin
      fails++;
      $display("FAIL bringup_ila_start got %0d exp 13 after rise", ila_t - rise_t);
    end
    checks++;
    if (data_t - ila_t != ILA_LEN || o_user_ready !== 1'b1) begin
      fails++;
      $display("FAIL bringup_ila_len got %0d ready %b exp %0d ready 1",
               data_t - ila_t, o_user_ready, ILA_LEN);
    end
  endtask

  task automatic test_sync_err();
    int rise_t;
    int err_t;
    int n_err;
    n_err = 0;
    err_t = -1;
    repeat (10) begin
      step(1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL syncerr_low t=%0d got %h exp %h", t, obs, exp_vec());
      end
    end
    step(1'b1);
    rise_t = t;
    repeat (6) begin
      step(1'b1);
      checks++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL syncerr_high t=%0d got %h exp %h", t, obs, exp_vec());
      end
      if (o_sync_err) begin
        n_err++;
        err_t = t;
      end
    end
    checks++;
    if (n_err != 1 || err_t != rise_t + 1 || o_link_mux !== 3'd0) begin
      fails++;
      $display("FAIL syncerr_pulse got n=%0d at +%0d mux=%0d exp n=1 at +1 mux=0",
               n_err, err_t - rise_t, o_link_mux);
    end
  endtask

  task automatic test_resync();
    int ila_t;
    int data_t;
    int n_err;
    n_err = 0;
    for (int pass = 0; pass < 2; pass++) begin
      repeat (60) begin
        step(1'b0);
        checks++;
        if (obs !== exp_vec()) begin
          fails++;
          $display("FAIL resync_drop t=%0d got %h exp %h", t, obs, exp_vec());
        end
      end
      ila_t = -1;
      for (int i = 0; i < 80 && ila_t < 0; i++) begin
        step(1'b1);
        checks++;
        if (obs !== exp_vec()) begin
          fails++;
          $display("FAIL resync_enter t=%0d got %h exp %h", t, obs, exp_vec());
        end
        if (o_link_mux == 3'd2) ila_t = t;
      end
      checks++;
      if (ila_t < 0) begin
        fails++;
        $display("FAIL resync_enter_timeout got mux %0d exp 2", o_link_mux);
      end
      // pass 0: mid-ILA; pass 1: 49th low lands on the final ILA boundary
      while (t < ((pass == 0) ? ila_t + 5 : ila_t + ILA_LEN - 1 - THRESH)) begin
        step(1'b1);
        checks++;
        if (obs !== exp_vec()) begin
          fails++;
          $display("FAIL resync_ila t=%0d got %h exp %h", t, obs, exp_vec());
        end
      end
      repeat (THRESH) begin
        step(1'b0);
        checks++;
        if (obs !== exp_vec()) begin
          fails++;
          $display("FAIL resync_low t=%0d got %h exp %h", t, obs, exp_vec());
        end
        n_err += int'(o_sync_err);
      end
      checks++;
      if (o_link_mux !== 3'd2) begin
        fails++;
        $display("FAIL resync_49th pass%0d got mux %0d exp 2", pass, o_link_mux);
      end
      step(1'b0);
      checks++;
      if (o_link_mux !== 3'd1 || o_user_ready !== 1'b0) begin
        fails++;
        $display("FAIL resync_cgs pass%0d got mux %0d exp 1", pass, o_link_mux);
      end
      ila_t  = -1;
      data_t = -1;
      for (int i = 0; i < 250 && data_t < 0; i++) begin
        step(1'b1);
        checks++;
        if (obs !== exp_vec()) begin
          fails++;
          $display("FAIL resync_again t=%0d got %h exp %h", t, obs, exp_vec());
        end
        n_err += int'(o_sync_err);
        if (ila_t < 0 && o_link_mux == 3'd2) ila_t = t;
        if (data_t < 0 && ila_t >= 0 && o_link_mux == 3'd0) data_t = t;
      end
      checks++;
      if (data_t - ila_t != ILA_LEN || ila_t < 0) begin
        fails++;
        $display("FAIL resync_repeat_ila got %0d exp %0d", data_t - ila_t, ILA_LEN);
      end
    end
    checks++;
    if (n_err != 0) begin
      fails++;
      $display("FAIL resync_no_err got %0d exp 0", n_err);
    end
  endtask

  task automatic test_boundary();
    int rise_t;
    int ila_t;
    ila_t = -1;
    repeat (60) begin
      step(1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL boundary_drop t=%0d got %h exp %h", t, obs, exp_vec());
      end
    end
    while ((t % MF) != MF - 2) begin
      step(1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL boundary_align t=%0d got %h exp %h", t, obs, exp_vec());
      end
    end
    step(1'b1);
    rise_t = t;
    for (int i = 0; i < 80 && ila_t < 0; i++) begin
      step(1'b1);
      checks++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL boundary_wait t=%0d got %h exp %h", t, obs, exp_vec());
      end
      if (o_link_mux == 3'd2) ila_t = t;
    end
    checks++;
    if (ila_t - rise_t != MF + 1 || o_no_frame_de_assertion !== 5'(K - 1)) begin
      fails++;
      $display("FAIL boundary_latency got %0d nfd %0d exp %0d nfd %0d",
               ila_t - rise_t, o_no_frame_de_assertion, MF + 1, K - 1);
    end
  endtask

  task automatic test_reset_mid_ila();
    repeat (40) begin
      step(1'b1);
      checks++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL midreset_ila t=%0d got %h exp %h", t, obs, exp_vec());
      end
    end
    #2;
    rst_n    = 1'b0;
    i_sync_n = 1'b0;
    #1;
    checks++;
    if (obs !== RST_VEC) begin
      fails++;
      $display("FAIL midreset_async got %h exp %h", obs, RST_VEC);
    end
    @(negedge clk);
    checks++;
    if (obs !== RST_VEC) begin
      fails++;
      $display("FAIL midreset_hold got %h exp %h", obs, RST_VEC);
    end
    rst_n = 1'b1;
    model_init();
    repeat (MF - 1) begin
      step(1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL midreset_restart t=%0d got %h exp %h", t, obs, exp_vec());
      end
    end
    checks++;
    if (o_lmfc !== 1'b1 || o_link_mux !== 3'd1) begin
      fails++;
      $display("FAIL midreset_lmfc got lmfc %b mux %0d exp 1 and 1", o_lmfc, o_link_mux);
    end
  endtask

  task automatic test_random();
    int remaining;
    int len;
    logic v;
    remaining = 1500;
    while (remaining > 0) begin
      v = 1'($urandom_range(0, 1));
      if (v) begin
        len = $urandom_range(20, 250);
      end else begin
        case ($urandom_range(0, 2))
          0:       len = $urandom_range(1, 12);
          1:       len = $urandom_range(THRESH - 2, THRESH + 2);
          default: len = $urandom_range(13, 80);
        endcase
      end
      for (int i = 0; i < len; i++) begin
        step(v);
        checks++;
        if (obs !== exp_vec()) begin
          fails++;
          $display("FAIL random t=%0d got %h exp %h", t, obs, exp_vec());
        end
        remaining--;
      end
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_sync_err();
    test_resync();
    test_boundary();
    test_reset_mid_ila();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
